// File: rtl/seg7_reader.sv
// seg7_reader: recovers the displayed m:ss count from three active-low 7-segment buses
// and flags illegal glyphs and counts that do not advance by exactly one second.
module seg7_reader #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] seg0,
   input  logic [6:0] seg1,
   input  logic [6:0] seg2,
   output logic [3:0] digit0,
   output logic [3:0] digit1,
   output logic [3:0] digit2,
   output logic [9:0] seconds,
   output logic       valid,
   output logic       tick,
   output logic [2:0] seg_err,
   output logic       seq_err
);
   localparam int CW = $clog2(STABLE_CYCLES);
   localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES - 1);
   typedef enum logic {IDLE, PRIMED} state_t;
   state_t state;
   logic [6:0] seg [3];
   logic [6:0] s [3];
   logic [CW-1:0] cnt [3];
   logic [4:0] dc [3];
   logic [2:0] ok, stable, bad;
   logic all_good;
   logic [9:0] new_sec;

   // {legal, digit}; anything outside the ten glyphs, blank included, is illegal
   function automatic logic [4:0] decode(input logic [6:0] p);
      case (p)
         7'b1000000: decode = 5'h10;
         7'b1111001: decode = 5'h11;
         7'b0100100: decode = 5'h12;
         7'b0110000: decode = 5'h13;
         7'b0011001: decode = 5'h14;
         7'b0010010: decode = 5'h15;
         7'b0000010: decode = 5'h16;
         7'b1111000: decode = 5'h17;
         7'b0000000: decode = 5'h18;
         7'b0010000: decode = 5'h19;
         default:    decode = 5'h00;
      endcase
   endfunction

   assign seg[0] = seg0;
   assign seg[1] = seg1;
   assign seg[2] = seg2;
   assign dc[0] = decode(s[0]);
   assign dc[1] = decode(s[1]);
   assign dc[2] = decode(s[2]);
   assign ok = {dc[2][4], dc[1][4] && dc[1][3:0] <= 4'd5, dc[0][4]};
   assign stable = {cnt[2] == CMAX, cnt[1] == CMAX, cnt[0] == CMAX};
   assign bad = stable & ~ok;
   assign all_good = &(stable & ok);
   assign new_sec = 10'(dc[2][3:0]) * 10'd60 + 10'(dc[1][3:0]) * 10'd10 + 10'(dc[0][3:0]);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 3; i++) begin
            s[i] <= '1;
            cnt[i] <= '0;
         end
         state <= IDLE;
         digit0 <= '0;
         digit1 <= '0;
         digit2 <= '0;
         seconds <= '0;
         valid <= 1'b0;
         tick <= 1'b0;
         seg_err <= '0;
         seq_err <= 1'b0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            s[i] <= seg[i];
            cnt[i] <= seg[i] != s[i] ? '0 : cnt[i] == CMAX ? cnt[i] : cnt[i] + 1'b1;
         end
         tick <= 1'b0;
         seg_err <= seg_err | bad;
         if (all_good && (state == IDLE || new_sec != seconds)) begin
            digit0 <= dc[0][3:0];
            digit1 <= dc[1][3:0];
            digit2 <= dc[2][3:0];
            seconds <= new_sec;
            valid <= 1'b1;
            tick <= 1'b1;
            state <= PRIMED;
            if (state == PRIMED && new_sec != seconds + 10'd1 && !(seconds == 10'd599 && new_sec == '0))
               seq_err <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_seg7_reader.sv
// tb_seg7_reader: table-driven scenarios, a full 0:00..9:59 sweep and random stimulus,
// each cycle compared against a history-window reference model.
module tb_seg7_reader;
   localparam int SC = 4;
   localparam logic [6:0] BLANK = 7'h7f;
   logic clk = 0, rst = 1;
   logic [6:0] seg0 = BLANK, seg1 = BLANK, seg2 = BLANK;
   logic [3:0] digit0, digit1, digit2;
   logic [9:0] seconds;
   logic valid, tick, seq_err;
   logic [2:0] seg_err;

   seg7_reader #(.STABLE_CYCLES(SC)) dut (
      .clk(clk), .rst(rst), .seg0(seg0), .seg1(seg1), .seg2(seg2),
      .digit0(digit0), .digit1(digit1), .digit2(digit2), .seconds(seconds),
      .valid(valid), .tick(tick), .seg_err(seg_err), .seq_err(seq_err)
   );

   always #10 clk = ~clk;

   logic [6:0] glyph [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
   int n_checks = 0, n_fail = 0, ticks = 0;

   // reference model: last SC samples per channel, stable when all SC agree
   logic [6:0] hist [3][SC];
   int fill [3];
   int m_d [3];
   int m_sec;
   bit m_valid, m_tick, m_seqerr;
   logic [2:0] m_segerr;

   function automatic int dec(input logic [6:0] p);
      for (int d = 0; d < 10; d++) if (glyph[d] == p) return d;
      return -1;
   endfunction

   function automatic logic [6:0] pat(input int d);
      return d <= 9 ? glyph[d] : BLANK;
   endfunction

   function automatic bit is_stable(input int i);
      if (fill[i] < SC) return 0;
      for (int k = 1; k < SC; k++) if (hist[i][k] != hist[i][0]) return 0;
      return 1;
   endfunction

   task automatic model_edge();
      logic [6:0] in [3];
      int nd [3];
      int ns;
      bit all_ok;
      in[0] = seg0; in[1] = seg1; in[2] = seg2;
      if (rst) begin
         m_d = '{0, 0, 0};
         m_sec = 0; m_valid = 0; m_tick = 0; m_seqerr = 0; m_segerr = 0;
         for (int i = 0; i < 3; i++) begin
            hist[i][0] = BLANK;
            fill[i] = 1;
         end
         return;
      end
      m_tick = 0;
      all_ok = 1;
      for (int i = 0; i < 3; i++) begin
         bit st, lg;
         st = is_stable(i);
         nd[i] = dec(hist[i][0]);
         lg = nd[i] >= 0 && !(i == 1 && nd[i] > 5);
         if (st && !lg) m_segerr[i] = 1;
         if (!(st && lg)) all_ok = 0;
      end
      if (all_ok) begin
         ns = nd[2] * 60 + nd[1] * 10 + nd[0];
         if (!m_valid || ns != m_sec) begin
            if (m_valid && ns != (m_sec + 1) % 600) m_seqerr = 1;
            m_d = nd; m_sec = ns; m_valid = 1; m_tick = 1;
         end
      end
      for (int i = 0; i < 3; i++) begin
         for (int k = SC - 1; k > 0; k--) hist[i][k] = hist[i][k-1];
         hist[i][0] = in[i];
         if (fill[i] < SC) fill[i]++;
      end
   endtask

   task automatic step();
      logic [27:0] act, exp;
      @(posedge clk);
      model_edge();
      #1;
      act = {digit2, digit1, digit0, seconds, valid, tick, seg_err, seq_err};
      exp = {4'(m_d[2]), 4'(m_d[1]), 4'(m_d[0]), 10'(m_sec), m_valid, m_tick, m_segerr, m_seqerr};
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL cycle_model t=%0t got=%h expected=%h", $time, act, exp);
      end
      ticks += tick;
   endtask

   task automatic hold(input logic [6:0] a2, input logic [6:0] a1, input logic [6:0] a0, input int n);
      seg2 = a2; seg1 = a1; seg0 = a0;
      repeat (n) step();
   endtask

   task automatic hold_val(input int v, input int n);
      hold(pat(v / 60), pat((v % 60) / 10), pat(v % 10), n);
   endtask

   task automatic expect_eq(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s got=%0d expected=%0d", name, act, exp);
      end
   endtask

   typedef struct {
      bit r;
      int m, t, o, n, sec, tk;
      bit vld;
      logic [2:0] se;
      bit qe;
   } vec_t;
   vec_t tbl [$];

   initial begin
      logic [6:0] p [3];
      int v;
      tbl.push_back('{1, 0, 0, 0, 1, 0, 0, 0, 3'b000, 0});
      tbl.push_back('{0, 0, 0, 0, 6, 0, 1, 1, 3'b000, 0});
      tbl.push_back('{0, 0, 0, 1, 6, 1, 1, 1, 3'b000, 0});
      tbl.push_back('{1, 0, 0, 9, 1, 0, 0, 0, 3'b000, 0});
      tbl.push_back('{0, 0, 0, 9, 6, 9, 1, 1, 3'b000, 0});
      tbl.push_back('{0, 0, 0, 0, 2, 9, 0, 1, 3'b000, 0});
      tbl.push_back('{0, 0, 1, 0, 6, 10, 1, 1, 3'b000, 0});
      tbl.push_back('{1, 0, 0, 5, 1, 0, 0, 0, 3'b000, 0});
      tbl.push_back('{0, 0, 0, 5, 6, 5, 1, 1, 3'b000, 0});
      tbl.push_back('{0, 0, 0, 15, 6, 5, 0, 1, 3'b001, 0});
      tbl.push_back('{0, 0, 0, 6, 6, 6, 1, 1, 3'b001, 0});
      tbl.push_back('{1, 0, 0, 5, 1, 0, 0, 0, 3'b000, 0});
      tbl.push_back('{0, 0, 0, 5, 6, 5, 1, 1, 3'b000, 0});
      tbl.push_back('{0, 0, 0, 7, 6, 7, 1, 1, 3'b000, 1});
      tbl.push_back('{0, 0, 0, 8, 6, 8, 1, 1, 3'b000, 1});
      tbl.push_back('{1, 1, 3, 0, 1, 0, 0, 0, 3'b000, 0});
      tbl.push_back('{0, 1, 3, 0, 6, 90, 1, 1, 3'b000, 0});
      tbl.push_back('{0, 2, 3, 0, 3, 90, 0, 1, 3'b000, 0});
      tbl.push_back('{0, 1, 3, 0, 6, 90, 0, 1, 3'b000, 0});
      tbl.push_back('{1, 1, 3, 0, 1, 0, 0, 0, 3'b000, 0});
      tbl.push_back('{0, 1, 3, 0, 6, 90, 1, 1, 3'b000, 0});
      tbl.push_back('{1, 0, 0, 0, 1, 0, 0, 0, 3'b000, 0});
      tbl.push_back('{0, 0, 0, 0, 6, 0, 1, 1, 3'b000, 0});
      tbl.push_back('{0, 0, 6, 0, 6, 0, 0, 1, 3'b010, 0});
      tbl.push_back('{1, 9, 5, 9, 1, 0, 0, 0, 3'b000, 0});
      tbl.push_back('{0, 9, 5, 9, 6, 599, 1, 1, 3'b000, 0});
      tbl.push_back('{0, 0, 0, 0, 6, 0, 1, 1, 3'b000, 0});

      hold(BLANK, BLANK, BLANK, 2);
      foreach (tbl[i]) begin
         ticks = 0;
         rst = tbl[i].r;
         hold(pat(tbl[i].m), pat(tbl[i].t), pat(tbl[i].o), tbl[i].n);
         rst = 0;
         n_checks++;
         if (seconds != 10'(tbl[i].sec) || ticks != tbl[i].tk || valid != tbl[i].vld ||
             seg_err != tbl[i].se || seq_err != tbl[i].qe) begin
            n_fail++;
            $display("FAIL vec%0d got sec=%0d ticks=%0d valid=%0b seg_err=%b seq_err=%0b expected sec=%0d ticks=%0d valid=%0b seg_err=%b seq_err=%0b",
                     i, seconds, ticks, valid, seg_err, seq_err,
                     tbl[i].sec, tbl[i].tk, tbl[i].vld, tbl[i].se, tbl[i].qe);
         end
      end

      rst = 1;
      hold_val(0, 1);
      rst = 0;
      hold_val(0, 6);
      ticks = 0;
      for (int k = 1; k <= 600; k++) hold_val(k % 600, 10);
      expect_eq("sweep_ticks", ticks, 600);
      expect_eq("sweep_seconds", int'(seconds), 0);
      expect_eq("sweep_seq_err", int'(seq_err), 0);
      expect_eq("sweep_seg_err", int'(seg_err), 0);

      v = 0;
      for (int i = 0; i < 3; i++) p[i] = glyph[0];
      for (int seg_n = 0; seg_n < 400; seg_n++) begin
         int kind, n, ch;
         kind = $urandom_range(0, 9);
         n = $urandom_range(1, 12);
         ch = $urandom_range(0, 2);
         if (kind == 0) begin
            rst = 1;
            hold(p[2], p[1], p[0], 1);
            rst = 0;
         end else if (kind == 7) begin
            p[ch] = 7'($urandom);
            hold(p[2], p[1], p[0], n);
         end else if (kind == 8) begin
            logic [6:0] keep;
            keep = p[ch];
            p[ch] = glyph[$urandom_range(0, 9)];
            hold(p[2], p[1], p[0], $urandom_range(1, SC - 1));
            p[ch] = keep;
            hold(p[2], p[1], p[0], n);
         end else begin
            v = kind == 6 ? int'($urandom_range(0, 599)) : (v + 1) % 600;
            p[2] = pat(v / 60); p[1] = pat((v % 60) / 10); p[0] = pat(v % 10);
            hold(p[2], p[1], p[0], n);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/seg7_reader.md
# seg7_reader

Reads back the three active-low 7-segment buses driven by the minute-counter display (seconds-ones, seconds-tens, minutes) and recovers the displayed count. It filters each bus for stability, decodes the glyph back to a BCD digit, and reports a combined seconds value with an update strobe. It flags illegal glyphs and any update that is not exactly +1 second with 9:59→0:00 wrap. It sits beside the display path as an on-chip monitor and self-check.

## Interface
- `STABLE_CYCLES`, default 4: consecutive identical samples required before a segment pattern is accepted. Legal values are ≥ 2.
- `clk`  input  1  system clock (50 MHz); all state updates on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `seg0`  input  7  seconds-ones segments, active-low, bit0 = a … bit6 = g.
- `seg1`  input  7  seconds-tens segments, same encoding.
- `seg2`  input  7  minutes segments, same encoding.
- `digit0`, `digit1`, `digit2`  output  4 each  last accepted digits.
- `seconds`  output  10  digit2*60 + digit1*10 + digit0, range 0–599.
- `valid`  output  1  high once the first full snapshot is taken.
- `tick`  output  1  one-cycle pulse on each snapshot update.
- `seg_err`  output  3  sticky per-channel illegal-glyph flags.
- `seq_err`  output  1  sticky out-of-sequence flag.

## Operation
- Glyph table, active-low, g..a order:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - All other patterns are illegal, including blank 1111111.
- Per channel: sample register `s`, stability counter `cnt`.
  - Each edge, `s` ← input.
  - If the new sample ≠ `s`, `cnt` ← 0. Otherwise `cnt` increments, saturating at STABLE_CYCLES-1.
  - The channel is stable when `cnt` = STABLE_CYCLES-1.
- Stable channel with an illegal glyph, or a legal glyph above 5 on channel 1: set that channel's `seg_err` bit. The snapshot is blocked while any channel is in this condition.
- Snapshot FSM, states IDLE → PRIMED:
  - IDLE, all three channels stable and legal: load digits/`seconds`, `valid` ← 1, `tick` pulse, go to PRIMED. No sequence check in IDLE.
  - PRIMED, all stable and legal, decoded value ≠ current `seconds`: load digits/`seconds` and pulse `tick`. Set `seq_err` unless new = old+1, or old = 599 and new = 0.
  - PRIMED, decoded value equals `seconds`: no action.
- Ones/tens carries that settle on different cycles produce one snapshot only, because the snapshot waits for all channels to be stable.
- `seconds` is computed combinationally from decoded digits with a 10-bit result. It is registered only on snapshot.
- Sticky flags clear only on `rst`.

## Timing
- Reset values:
  - outputs: `digit*`=0, `seconds`=0, `valid`=0, `tick`=0, `seg_err`=000, `seq_err`=0
  - internal: `s`=1111111, `cnt`=0, FSM=IDLE
- Let E0 be the first edge that samples a new pattern. The channel is stable after edge E0+STABLE_CYCLES-1. Digits, `seconds` and `tick` update on edge E0+STABLE_CYCLES; `tick` is high for exactly that one cycle.
- `seg_err` / `seq_err` assert on the same edge as the corresponding snapshot decision.
- A glitch shorter than STABLE_CYCLES samples restarts the counter and causes no update and no error.
- `rst` mid-filter or mid-pulse: all state returns to reset values on that edge and `tick` drops immediately. After `rst` releases, the first snapshot needs a full STABLE_CYCLES window.

## Test plan
- Reset, then hold seg0=1000000, seg1=1000000, seg2=1000000 → after 4 edges: `valid`=1, one `tick`, `seconds`=0, no errors.
- From 0:00, step the display 0:00→0:01→…→9:59→0:00, each value held 10 cycles → 600 ticks, final `seconds`=0, `seq_err`=0, `seg_err`=000.
- From 0:09, seg0 changes to 0 two cycles before seg1 changes to 1 → exactly one `tick`, `seconds`=10, `seq_err`=0.
- From 0:05, seg0 = 1111111 for 4+ cycles → `seg_err`[0]=1, `seconds` stays 5, no `tick`. Then seg0 = glyph 6 → `tick`, `seconds`=6.
- From 0:05, jump to 0:07 → `tick`, `seconds`=7, `seq_err`=1. A following 0:08 step sets no new error; the flag remains set.
- 3-cycle glitch on seg2 at 1:30 → no `tick`. Then assert `rst` for 1 cycle → all outputs reset; re-prime at 1:30 gives `seconds`=90, `seq_err`=0.
